serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer that drives the team's single-bit full_adder cell, one bit per clock, LSB first. It latches two WIDTH-bit operands and a carry-in, presents one bit pair plus the stored carry to the full adder each cycle, and collects the returned sum and carry bits. When all bits are done it reports a WIDTH-bit sum and a carry-out. Sits directly upstream of full_adder (drives a/b/c) and consumes its combinational sum/carry.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; accepted only in IDLE
a_in  input  WIDTH  operand A, sampled on the accepting edge
b_in  input  WIDTH  operand B, sampled on the accepting edge
cin  input  1  carry-in, sampled on the accepting edge
fa_a  output  1  to full_adder.a: current bit of A
fa_b  output  1  to full_adder.b: current bit of B
fa_c  output  1  to full_adder.c: stored carry
fa_sum  input  1  from full_adder.sum, combinational
fa_carry  input  1  from full_adder.carry, combinational
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, result valid
sum_out  output  WIDTH  final sum; holds until next completion or reset
cout  output  1  final carry-out; holds with sum_out

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; shift registers, carry register, bit counter, sum_out, cout, done, busy all 0. fa_a/fa_b/fa_c = 0.
- Reset is synchronous only: rst_n going low between edges has no effect until the next edge.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge -> load a_sh=a_in, b_sh=b_in, carry_q=cin, cnt=0, clear internal sum shift register; next state RUN. start=0 -> stay.
- RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry_q (combinational from registers). On each edge: sum_sh shifts right with fa_sum entering at MSB; carry_q<=fa_carry; a_sh, b_sh shift right (0 fill); cnt++.
- RUN -> DONE on the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge). On that same edge, sum_out <= final sum (last fa_sum at MSB, previous bits below) and cout <= fa_carry.
- DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E0+WIDTH (WIDTH+1 edges from start to done). Next start is accepted at the earliest on edge E0+WIDTH+1 (back in IDLE).
- start in RUN or DONE is ignored: no operand re-sampling, no queuing.
- fa_a/fa_b/fa_c are 0 outside RUN.
- sum_out/cout never show partial results; they change only on the RUN->DONE edge or on reset.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-RUN: operation aborted, done not asserted, sum_out/cout cleared to 0, state IDLE on the next cycle.
- start and rst_n=0 on the same edge: reset wins and start is dropped.

Test Plan:
1. WIDTH=8, a=0x00, b=0x00, cin=0, start 1 cycle -> fa_c=0 in first RUN cycle; done pulses exactly 9 edges after start; sum_out=0x00, cout=0; busy high for 9 cycles.
2. a=0xFF, b=0x01, cin=0 -> carry ripples through all 8 bits; sum_out=0x00, cout=1; fa_c=1 from RUN cycle 2 onward.
3. a=0xA5, b=0x5A, cin=1 -> first cycle fa_a=1, fa_b=0, fa_c=1; sum_out=0x00, cout=1. a=0x3C, b=0x42, cin=0 -> sum_out=0x7E, cout=0.
4. Start 0x3C+0x42; re-assert start with a=0xFF, b=0xFF at RUN cycle 3 and during DONE -> ignored; result 0x7E/0; only one done pulse; new start accepted in the following IDLE cycle.
5. Complete 0xFF+0x01 (sum 0x00, cout 1); start 0x12+0x34; pull rst_n low at RUN cycle 4 -> next cycle state IDLE, sum_out=0x00, cout=0, busy=0, no done; then 0x12+0x34 -> sum_out=0x46, cout=0.
6. rst_n=0 with start=1 on the same edge -> no operation begins; busy stays 0; fa_* stay 0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer for the single-bit full_adder
// cell. It latches two WIDTH-bit operands and a carry-in, feeds one bit pair
// plus the stored carry to the cell each cycle (LSB first), and gathers the
// returned sum and carry bits into a WIDTH-bit result and a carry-out.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Holds the WIDTH-1 lower sum bits; the last bit arrives straight from the
  // cell on the final edge, so it never needs a register slot of its own.
  logic [WIDTH-2:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout;
  logic [WIDTH-1:0] w_sum_next;

  // Newest sum bit enters at the MSB; on the final edge this is the result.
  assign w_sum_next = {fa_sum, r_sum_sh};

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode plus the state-derived outputs.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    fa_a     = 1'b0;
    fa_b     = 1'b0;
    fa_c     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        fa_a = r_a_sh[0];
        fa_b = r_b_sh[0];
        fa_c = r_carry;
        if (r_cnt == LAST_BIT) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/sum shifting, carry and bit counter; result latched on last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_sum_out <= '0;
      r_cout    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= a_in;
      r_b_sh   <= b_in;
      r_sum_sh <= '0;
      r_carry  <= cin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh <= w_sum_next[WIDTH-1:1];
      r_carry  <= fa_carry;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum_out <= w_sum_next;
        r_cout    <= fa_carry;
      end
    end
  end

  assign sum_out = r_sum_out;
  assign cout    = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed test of the bit-serial adder sequencer with a
// behavioural full_adder cell and a cycle-level arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             fa_a, fa_b, fa_c;
  logic             fa_sum, fa_carry;
  logic             busy, done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural single-bit full adder cell.
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .cin(cin), .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sum(fa_sum),
    .fa_carry(fa_carry), .busy(busy), .done(done), .sum_out(sum_out),
    .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1..WIDTH = working on bit phase-1,
  // WIDTH+1 = result cycle. Carry into bit k comes from plain addition of the
  // low k bits of each operand.
  int               m_phase = 0;
  bit               m_valid = 1'b0;
  logic [63:0]      m_a, m_b, m_cin, m_res;
  logic [WIDTH-1:0] m_sum_out;
  logic             m_cout;

  function automatic logic carry_into(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c, input int k);
    logic [63:0] mask;
    mask = (64'd1 << k) - 64'd1;
    return logic'((((a & mask) + (b & mask) + c) >> k) & 64'd1);
  endfunction

  // Update the model on each edge, then compare all outputs 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_phase   = 0;
        m_sum_out = '0;
        m_cout    = 1'b0;
        m_valid   = 1'b1;
      end else if (m_phase == 0) begin
        if (start) begin
          m_a     = 64'(a_in);
          m_b     = 64'(b_in);
          m_cin   = 64'(cin);
          m_res   = m_a + m_b + m_cin;
          m_phase = 1;
        end
      end else if (m_phase <= WIDTH) begin
        if (m_phase == WIDTH) begin
          m_sum_out = m_res[WIDTH-1:0];
          m_cout    = m_res[WIDTH];
        end
        m_phase++;
      end else begin
        m_phase = 0;
      end
      #1;
      if (m_valid) begin
        bit run;
        run = (m_phase >= 1) && (m_phase <= WIDTH);
        check("cmp_busy", 64'(busy), 64'(m_phase != 0));
        check("cmp_done", 64'(done), 64'(m_phase == WIDTH + 1));
        check("cmp_fa_a", 64'(fa_a), run ? 64'(m_a[m_phase-1]) : 64'd0);
        check("cmp_fa_b", 64'(fa_b), run ? 64'(m_b[m_phase-1]) : 64'd0);
        check("cmp_fa_c", 64'(fa_c),
              run ? 64'(carry_into(m_a, m_b, m_cin, m_phase - 1)) : 64'd0);
        check("cmp_sum_out", 64'(sum_out), 64'(m_sum_out));
        check("cmp_cout", 64'(cout), 64'(m_cout));
      end
    end
  end

  logic first_fa_a, first_fa_b, first_fa_c;
  int   lat_edges, busy_cycles;

  // One complete operation: pulse start, wait (bounded) for done.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c);
    bit seen;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_fa_a  = fa_a;
    first_fa_b  = fa_b;
    first_fa_c  = fa_c;
    busy_cycles = busy ? 1 : 0;
    lat_edges   = 0;
    seen        = 1'b0;
    for (int i = 1; i <= 3 * WIDTH && !seen; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        seen      = 1'b1;
        lat_edges = i + 1;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_fa", 64'({fa_a, fa_b, fa_c}), 64'd0);
    check("reset_sum", 64'({cout, sum_out}), 64'd0);
    rst_n = 1'b1;

    // 1: zeros
    do_op(8'h00, 8'h00, 1'b0);
    check("t1_first_fa_c", 64'(first_fa_c), 64'd0);
    check("t1_latency", 64'(lat_edges), 64'd9);
    check("t1_busy_cycles", 64'(busy_cycles), 64'd9);
    check("t1_result", 64'({cout, sum_out}), 64'h000);

    // 2: full carry ripple
    do_op(8'hFF, 8'h01, 1'b0);
    check("t2_result", 64'({cout, sum_out}), 64'h100);

    // 3: carry-in and a no-carry case
    do_op(8'hA5, 8'h5A, 1'b1);
    check("t3_first_fa", 64'({first_fa_a, first_fa_b, first_fa_c}), 64'b101);
    check("t3_result_a", 64'({cout, sum_out}), 64'h100);
    do_op(8'h3C, 8'h42, 1'b0);
    check("t3_result_b", 64'({cout, sum_out}), 64'h07E);

    // 4: start during RUN and DONE ignored; start held into IDLE accepted
    @(negedge clk);
    a_in = 8'h3C; b_in = 8'h42; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;                    // RUN cycle 1
    @(negedge clk);                                  // RUN cycle 2
    @(negedge clk); a_in = 8'hFF; b_in = 8'hFF; start = 1'b1; // RUN cycle 3
    @(negedge clk); start = 1'b0;
    dones = 0;
    for (int i = 0; i < 3 * WIDTH && !done; i++) @(negedge clk);
    check("t4_done_seen", 64'(done), 64'd1);
    check("t4_result", 64'({cout, sum_out}), 64'h07E);
    start = 1'b1;                                    // asserted during DONE
    @(negedge clk);                                  // IDLE: still held
    check("t4_idle_after_done", 64'(busy), 64'd0);
    @(negedge clk); start = 1'b0;
    check("t4_restart_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3 * WIDTH && !done; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("t4_second_done", 64'(dones), 64'd1);
    check("t4_second_result", 64'({cout, sum_out}), 64'h1FE);
    @(negedge clk);

    // 5: reset mid-RUN
    do_op(8'hFF, 8'h01, 1'b0);
    check("t5_pre_result", 64'({cout, sum_out}), 64'h100);
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;                    // RUN cycle 1
    repeat (3) @(negedge clk);                       // RUN cycle 4
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_result", 64'({cout, sum_out}), 64'h000);
    dones = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("t5_no_done", 64'(dones), 64'd0);
    do_op(8'h12, 8'h34, 1'b0);
    check("t5_result", 64'({cout, sum_out}), 64'h046);

    // 6: reset wins over start on the same edge
    @(negedge clk);
    a_in = 8'h77; b_in = 8'h11; rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_fa", 64'({fa_a, fa_b, fa_c}), 64'd0);
    @(negedge clk);
    check("t6_busy_later", 64'(busy), 64'd0);
    check("t6_fa_later", 64'({fa_a, fa_b, fa_c}), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
